flash_read_arbiter: RTL and testbench

Two-port read arbiter that shares one `axi_controller` request port (and therefore the AXI flash controller behind it) between an instruction-fetch requester (port 0) and a data-load requester (port 1). It grants one read at a time using round-robin priority, sequences the request/ready/done handshake toward the controller, and returns the registered data to the winner. It also holds a single-word last-read buffer, so a repeated read of the same word completes without a flash access. It sits between the core's fetch/load units and the `amif` side of `axi_controller`.

---
 rtl/flash_read_arbiter.sv | 96 +++++++++
 tb/tb_flash_read_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_arbiter.sv
// Two-port round-robin read arbiter in front of one AXI flash controller port,
// with a single-word last-read buffer that short-circuits repeated word reads.
module flash_read_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int HIT_BUF_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_read,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  output logic [1:0]             req_ready,
  output logic [DATA_W-1:0]      req_load,
  input  logic [1:0]             req_done,
  input  logic                   flush,
  output logic                   mem_read,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_load,
  output logic                   mem_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q;
  logic                gnt_q;
  logic                prio_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                buf_valid_q;
  logic [ADDR_W-3:0]   buf_addr_q;
  logic [DATA_W-1:0]   buf_data_q;

  logic                gnt_sel;
  logic                hit;

  // Contention goes to prio_q; otherwise whichever single port is asking.
  always_comb begin
    gnt_sel = (req_read == 2'b11) ? prio_q : req_read[1];
    hit     = (HIT_BUF_EN != 0) && buf_valid_q && !flush &&
              (req_addr[gnt_sel][ADDR_W-1:2] == buf_addr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      prio_q      <= 1'b0;
      addr_q      <= '0;
      rdata_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_read) begin
            gnt_q  <= gnt_sel;
            addr_q <= req_addr[gnt_sel];
            if (hit) begin
              rdata_q <= buf_data_q;
              state_q <= RESP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            rdata_q     <= mem_load;
            buf_addr_q  <= addr_q[ADDR_W-1:2];
            buf_data_q  <= mem_load;
            buf_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (req_done[gnt_q]) begin
            prio_q  <= ~gnt_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Placed last so a same-cycle refill from ISSUE cannot revalidate.
      if (flush) buf_valid_q <= 1'b0;
    end
  end

  assign mem_read  = (state_q == ISSUE);
  assign mem_addr  = mem_read ? addr_q : '0;
  assign mem_done  = mem_read & mem_ready;
  assign req_ready = (state_q != RESP) ? 2'b00 : (gnt_q ? 2'b10 : 2'b01);
  assign req_load  = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench for flash_read_arbiter: drivers queue expected responses,
// a monitor pops and compares whenever req_ready is presented.
module tb_flash_read_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DLY = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_read, req_ready, req_done;
  logic [1:0][AW-1:0]  req_addr;
  logic [DW-1:0]       req_load;
  logic [DW-1:0]       mem_load = '0;
  logic                flush, flush_stim, flush_race;
  logic                flush_ctl = 1'b0;
  logic                mem_read, mem_done;
  logic                mem_ready = 1'b0;
  logic [AW-1:0]       mem_addr;
  int                  n_chk = 0, n_fail = 0, n_acc = 0, cnt = 0;

  typedef struct packed {logic port; logic [DW-1:0] data;} rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;

  always #5 clk = ~clk;
  assign flush = flush_stim | flush_ctl;

  flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HIT_BUF_EN(1)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_addr(req_addr),
    .req_ready(req_ready), .req_load(req_load), .req_done(req_done),
    .flush(flush), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_load(mem_load), .mem_done(mem_done)
  );

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = {a[AW-1:2], 2'b00};
    case (w)
      32'h0080_0D90: return 32'hDEAD_BEEF;
      32'h0080_167C: return 32'h1670_C0DE;
      32'h0080_112C: return 32'h112C_F00D;
      32'h0080_0140: return 32'h0140_ABCD;
      default:       return {16'hBAD0, w[15:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic [DW-1:0] d);
    rsp_t e;
    e.port = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Flash controller model: ready DLY cycles after first seeing mem_read.
  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0; flush_ctl = 1'b0; cnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0; flush_ctl = 1'b0; cnt = 0;
    end else if (mem_read) begin
      if (cnt == DLY) begin
        mem_ready = 1'b1;
        mem_load  = mem_fn(mem_addr);
        flush_ctl = flush_race;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  always begin
    @(negedge clk);
    #1;
    check("mem_done", mem_done, mem_read & mem_ready);
    if (!mem_read) check("mem_addr_idle", mem_addr, 0);
    if (req_ready == 2'b00) check("req_load_idle", req_load, 0);
    if (mem_done) n_acc++;
    if (req_ready != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rsp: got ready %b with no response expected", req_ready);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_port", req_ready, mon_e.port ? 2'b10 : 2'b01);
        check("rsp_data", req_load, mon_e.data);
      end
    end
  end

  // mode: 0 = expect miss, 1 = expect hit, 2 = no latency check (contention)
  task automatic do_read(input logic p, input logic [AW-1:0] a, input int mode);
    int lat, acc0;
    bit got;
    lat = 0; got = 0; acc0 = n_acc;
    req_addr[p] = a;
    req_read[p] = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (req_ready[p]) got = 1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: port %0d addr %h got no ready, required one", p, a);
      req_read[p] = 1'b0;
      return;
    end
    req_done[p] = 1'b1;
    req_read[p] = 1'b0;
    if (mode == 0) begin
      check("miss_lat", lat, DLY + 2);
      check("miss_acc", n_acc - acc0, 1);
    end else if (mode == 1) begin
      check("hit_lat", lat, 1);
      check("hit_acc", n_acc - acc0, 0);
    end
    @(negedge clk);
    req_done[p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; req_read = '0; req_done = '0; req_addr = '0;
    flush_stim = 1'b0; flush_race = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_req_load", req_load, 0);
    @(negedge clk);
    rst = 1'b0;

    // Contention from reset: port 0 first, twice.
    for (int r = 0; r < 2; r++) begin
      push(0, 32'h1670_C0DE);
      push(1, 32'h112C_F00D);
      fork
        do_read(0, 32'h0080_167C, 2);
        do_read(1, 32'h0080_112C, 2);
      join
    end

    // Single miss, then same-word hit from the other port.
    push(0, 32'hDEAD_BEEF);
    do_read(0, 32'h0080_0D90, 0);
    push(1, 32'hDEAD_BEEF);
    do_read(1, 32'h0080_0D92, 1);

    // Port 0 alone leaves prio at 1, so contention now serves port 1 first.
    push(0, 32'h1670_C0DE);
    do_read(0, 32'h0080_167C, 0);
    push(1, 32'h112C_F00D);
    push(0, 32'hDEAD_BEEF);
    fork
      do_read(0, 32'h0080_0D90, 2);
      do_read(1, 32'h0080_112C, 2);
    join

    // Flush while idle invalidates a valid hit.
    push(1, 32'hDEAD_BEEF);
    do_read(1, 32'h0080_0D90, 1);
    flush_stim = 1'b1;
    @(negedge clk);
    flush_stim = 1'b0;
    push(0, 32'hDEAD_BEEF);
    do_read(0, 32'h0080_0D93, 0);

    // Flush coincident with mem_ready wins over the refill.
    flush_race = 1'b1;
    push(1, 32'h112C_F00D);
    do_read(1, 32'h0080_112C, 0);
    flush_race = 1'b0;
    push(1, 32'h112C_F00D);
    do_read(1, 32'h0080_112C, 0);
    push(0, 32'h112C_F00D);
    do_read(0, 32'h0080_112D, 1);

    // Flush in the grant cycle blocks a matching hit.
    push(0, 32'h112C_F00D);
    fork
      do_read(0, 32'h0080_112C, 0);
      begin
        flush_stim = 1'b1;
        @(negedge clk);
        flush_stim = 1'b0;
      end
    join

    // Reset mid-ISSUE (prio is 1 going in).
    req_addr[0] = 32'h0080_0140;
    req_read[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_read) seen = 1;
    end
    check("issue_reached", seen, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_read", mem_read, 0);
    check("arst_mem_done", mem_done, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_req_ready", req_ready, 0);
    check("arst_req_load", req_load, 0);
    req_read[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push(0, 32'h0140_ABCD);
    push(1, 32'h1670_C0DE);
    fork
      do_read(0, 32'h0080_0140, 2);
      do_read(1, 32'h0080_167C, 2);
    join
    push(0, 32'h0140_ABCD);
    do_read(0, 32'h0080_0140, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
